// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, constants and byte/word helpers.
package aes_pkg;

   typedef logic [0:31] aes_word_t;

   typedef enum logic [1:0] {
      AES_128  = 2'd0,
      AES_192  = 2'd1,
      AES_256  = 2'd2,
      AES_RSVD = 2'd3
   } key_len_e;

   localparam logic [7:0] RCON_INIT = 8'h01;

   // Forward S-box, entry 0 in the leftmost byte.
   localparam logic [0:2047] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [3:0] nk_of(input key_len_e len);
      case (len)
         AES_128: return 4'd4;
         AES_192: return 4'd6;
         AES_256: return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input key_len_e len);
      case (len)
         AES_128: return 4'd10;
         AES_192: return 4'd12;
         AES_256: return 4'd14;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic aes_word_t rot_word(input aes_word_t w);
      return {w[8:31], w[0:7]};
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[{b, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/aes_key_word_gen.sv
// Combinational next-word logic for the key schedule (i >= Nk only).
// sub_o is the raw SubWord result; sub_i is the value actually used, so the
// caller may insert a register between them.
module aes_key_word_gen
   import aes_pkg::*;
(
   input  aes_word_t   prev_i,
   input  aes_word_t   far_i,
   input  logic [2:0]  j_i,
   input  logic [3:0]  nk_i,
   input  logic [7:0]  rcon_i,
   output aes_word_t   sub_o,
   input  aes_word_t   sub_i,
   output aes_word_t   word_o
);

   aes_word_t sub_in;
   aes_word_t temp;

   assign sub_in = (j_i == 3'd0) ? rot_word(prev_i) : prev_i;

   sub_bytes #(4) u_sub_bytes (
      .data_i (sub_in),
      .data_o (sub_o)
   );

   always_comb begin
      temp = prev_i;
      if (j_i == 3'd0)
         temp = sub_i ^ {rcon_i, 24'h000000};
      else if (nk_i == 4'd8 && j_i == 3'd4)
         temp = sub_i;
   end

   assign word_o = far_i ^ temp;

endmodule

// File: rtl/sub_bytes.sv
// Parallel AES S-box substitution over n_p bytes, byte 0 leftmost.
module sub_bytes
   import aes_pkg::*;
#(
   parameter int n_p = 4
) (
   input  logic [0:8*n_p-1] data_i,
   output logic [0:8*n_p-1] data_o
);

   for (genvar b = 0; b < n_p; b++) begin : g_byte
      assign data_o[8*b +: 8] = sbox(data_i[8*b +: 8]);
   end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key expansion, one schedule word per cycle.
// Define AES_KEY_EXPAND_SBOX_PIPE_EN to register SubWord (one stall per SubWord word).
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int max_nk_p = 8
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [0:32*max_nk_p-1] key_i,
   input  logic [1:0]             key_len_i,
   input  logic                   v_i,
   output logic                   ready_o,
   input  logic                   abort_i,
   output logic [0:127]           rk_o,
   output logic [3:0]             rk_idx_o,
   output logic                   rk_last_o,
   output logic                   v_o,
   input  logic                   yumi_i,
   output logic                   err_o
);

   typedef enum logic {IDLE, GEN} state_e;

   state_e       state_q;
   aes_word_t    win_q [8];
   aes_word_t    asm_q [3];
   logic [1:0]   asm_cnt_q;
   logic [5:0]   i_q;
   logic [2:0]   j_q;
   logic [7:0]   rcon_q;
   logic [3:0]   nk_q;
   logic [3:0]   nr_q;
   logic [0:127] rk_q;
   logic [3:0]   idx_q;
   logic         last_q;
   logic         v_q;
   logic         err_q;

   logic [0:255] key_pad;
   aes_word_t    key_w [8];
   logic [3:0]   nk_in;
   logic         illegal;
   aes_word_t    far_w;
   aes_word_t    gen_w;
   aes_word_t    new_w;
   aes_word_t    sub_raw;
   aes_word_t    sub_use;
   logic [5:0]   total_w;
   logic         key_phase;
   logic         gen_ok;
   logic         step;

   always_comb begin
      key_pad = '0;
      key_pad[0:32*max_nk_p-1] = key_i;
      for (int k = 0; k < 8; k++) key_w[k] = key_pad[32*k +: 32];
   end

   assign nk_in   = nk_of(key_len_e'(key_len_i));
   assign illegal = (nk_in == 4'd0) || (int'(nk_in) > max_nk_p);

   // Oldest live word w[i-Nk] sits at window[Nk-1].
   always_comb begin
      case (nk_q)
         4'd6:    far_w = win_q[5];
         4'd8:    far_w = win_q[7];
         default: far_w = win_q[3];
      endcase
   end

   aes_key_word_gen u_word_gen (
      .prev_i (win_q[0]),
      .far_i  (far_w),
      .j_i    (j_q),
      .nk_i   (nk_q),
      .rcon_i (rcon_q),
      .sub_o  (sub_raw),
      .sub_i  (sub_use),
      .word_o (gen_w)
   );

   assign total_w   = {nr_q + 4'd1, 2'b00};
   assign key_phase = i_q < {2'b00, nk_q};
   assign new_w     = key_phase ? far_w : gen_w;
   assign gen_ok    = (state_q == GEN) && (i_q < total_w) &&
                      !((asm_cnt_q == 2'd3) && v_q && !yumi_i);

`ifdef AES_KEY_EXPAND_SBOX_PIPE_EN
   logic      need_sub;
   logic      sub_ph_q;
   aes_word_t sub_q;

   assign need_sub = !key_phase && ((j_q == 3'd0) || (nk_q == 4'd8 && j_q == 3'd4));
   assign sub_use  = sub_q;
   assign step     = gen_ok && (!need_sub || sub_ph_q);

   always_ff @(posedge clk_i) begin
      if (reset_i || abort_i) begin
         sub_ph_q <= 1'b0;
      end else if (gen_ok && need_sub) begin
         if (!sub_ph_q) sub_q <= sub_raw;
         sub_ph_q <= !sub_ph_q;
      end
   end
`else
   assign sub_use = sub_raw;
   assign step    = gen_ok;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         v_q       <= 1'b0;
         rk_q      <= '0;
         idx_q     <= '0;
         last_q    <= 1'b0;
         err_q     <= 1'b0;
         asm_cnt_q <= '0;
         i_q       <= '0;
         j_q       <= '0;
         rcon_q    <= RCON_INIT;
         nk_q      <= 4'd4;
         nr_q      <= 4'd10;
      end else begin
         err_q <= 1'b0;
         if (abort_i) begin
            state_q   <= IDLE;
            v_q       <= 1'b0;
            asm_cnt_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (v_i) begin
                     if (illegal) begin
                        err_q <= 1'b1;
                     end else begin
                        // Load reversed so the rotating window replays key words in order.
                        case (nk_in)
                           4'd6:    for (int k = 0; k < 6; k++) win_q[k] <= key_w[5-k];
                           4'd8:    for (int k = 0; k < 8; k++) win_q[k] <= key_w[7-k];
                           default: for (int k = 0; k < 4; k++) win_q[k] <= key_w[3-k];
                        endcase
                        nk_q      <= nk_in;
                        nr_q      <= nr_of(key_len_e'(key_len_i));
                        i_q       <= '0;
                        j_q       <= '0;
                        rcon_q    <= RCON_INIT;
                        asm_cnt_q <= '0;
                        state_q   <= GEN;
                     end
                  end
               end
               GEN: begin
                  if (yumi_i && v_q) begin
                     v_q <= 1'b0;
                     if (last_q) state_q <= IDLE;
                  end
                  if (step) begin
                     for (int k = 1; k < 8; k++) win_q[k] <= win_q[k-1];
                     win_q[0] <= new_w;
                     i_q      <= i_q + 6'd1;
                     j_q      <= ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
                     if (!key_phase && j_q == 3'd0) rcon_q <= xtime(rcon_q);
                     asm_q[0] <= asm_q[1];
                     asm_q[1] <= asm_q[2];
                     asm_q[2] <= new_w;
                     if (asm_cnt_q == 2'd3) begin
                        rk_q      <= {asm_q[0], asm_q[1], asm_q[2], new_w};
                        idx_q     <= i_q[5:2];
                        last_q    <= (i_q[5:2] == nr_q);
                        v_q       <= 1'b1;
                        asm_cnt_q <= '0;
                     end else begin
                        asm_cnt_q <= asm_cnt_q + 2'd1;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign ready_o   = (state_q == IDLE);
   assign rk_o      = rk_q;
   assign rk_idx_o  = idx_q;
   assign rk_last_o = last_q;
   assign v_o       = v_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: FIPS-197 vectors plus an independent schedule model.
module tb_aes_key_expand;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic [0:255] key_i;
   logic [1:0]   key_len_i;
   logic         v_i;
   logic         ready_o;
   logic         abort_i;
   logic [0:127] rk_o;
   logic [3:0]   rk_idx_o;
   logic         rk_last_o;
   logic         v_o;
   logic         yumi_i;
   logic         err_o;

   logic yumi_fix, yumi_rand, yumi_rnd;

   typedef struct {
      logic [127:0] rk;
      logic [3:0]   idx;
      logic         last;
   } exp_t;

   exp_t         exp_q[$];
   logic [7:0]   sb [256];
   int           checks = 0;
   int           failures = 0;
   int           err_cnt = 0;
   logic [127:0] last_rk = '0;

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   always #5 clk_i = ~clk_i;

   assign yumi_i = v_o && (yumi_rand ? yumi_rnd : yumi_fix);

   always @(posedge clk_i) begin
      #1;
      yumi_rnd = 1'($urandom_range(0, 1));
   end

   aes_key_expand #(.max_nk_p(8)) dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .key_i     (key_i),
      .key_len_i (key_len_i),
      .v_i       (v_i),
      .ready_o   (ready_o),
      .abort_i   (abort_i),
      .rk_o      (rk_o),
      .rk_idx_o  (rk_idx_o),
      .rk_last_o (rk_last_o),
      .v_o       (v_o),
      .yumi_i    (yumi_i),
      .err_o     (err_o)
   );

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         aa = xt(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // S-box derived from GF(2^8) inversion plus the affine map.
   task automatic build_sbox();
      logic [7:0] inv, r, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv; r = inv;
         for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
         end
         sb[x] = s ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic push_expected(input logic [255:0] key, input int nk, input int nkeys);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nr, total;
      exp_t        e;
      nr = nk + 6; total = 4 * (nr + 1); rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < total; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk == 8 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < nkeys; r++) begin
         e.rk   = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         e.idx  = 4'(r);
         e.last = (r == nr);
         exp_q.push_back(e);
      end
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=expired required=event", nm);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_key(input logic [255:0] key, input logic [1:0] len);
      int n = 0;
      while (!ready_o && n < 200) begin tick(); n++; end
      key_i = key; key_len_i = len; v_i = 1'b1;
      tick();
      v_i = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || v_o) && n < 3000) begin tick(); n++; end
      if (n >= 3000) begin
         timeout(nm);
         exp_q.delete();
      end
   endtask

   task automatic wait_v(input string nm);
      int n = 0;
      while (!v_o && n < 200) begin tick(); n++; end
      if (n >= 200) timeout(nm);
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (!reset_i) begin
         if (err_o) err_cnt++;
         if (v_o && yumi_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rk actual=%h required=none", rk_o);
            end else begin
               e = exp_q.pop_front();
               chk("rk_val", rk_o, e.rk);
               chk("rk_idx", 128'(rk_idx_o), 128'(e.idx));
               chk("rk_last", 128'(rk_last_o), 128'(e.last));
            end
            last_rk = rk_o;
         end
      end
   end

   initial begin
      int n;
      reset_i = 1'b1; v_i = 1'b0; abort_i = 1'b0; key_i = '0; key_len_i = 2'd0;
      yumi_fix = 1'b0; yumi_rand = 1'b0;
      build_sbox();
      repeat (3) tick();
      reset_i = 1'b0;

      chk("reset_ready", 128'(ready_o), 128'd1);
      chk("reset_v", 128'(v_o), 128'd0);
      chk("reset_rk", rk_o, 128'd0);
      chk("reset_idx", 128'(rk_idx_o), 128'd0);
      chk("reset_last", 128'(rk_last_o), 128'd0);
      chk("reset_err", 128'(err_o), 128'd0);

      // AES-128, consumer always ready
      yumi_fix = 1'b1;
      push_expected(K128, 4, 11);
      send_key(K128, 2'd0);
      chk("busy_after_accept", 128'(ready_o), 128'd0);
      n = 0;
      while (!v_o && n < 20) begin tick(); n++; end
      chk("first_v_latency", 128'(n), 128'd4);
      drain("aes128");
      chk("aes128_ready_after_last", 128'(ready_o), 128'd1);
      chk("aes128_rk10", last_rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      push_expected(K192, 6, 13);
      send_key(K192, 2'd1);
      drain("aes192");
      chk("aes192_rk12", last_rk, 128'he98ba06f448c773c8ecc720401002202);

      push_expected(K256, 8, 15);
      send_key(K256, 2'd2);
      drain("aes256");
      chk("aes256_rk14", last_rk, 128'hfe4890d1e6188d0b046df344706c631e);

      // AES-256 with a held-off consumer, then random acceptance
      yumi_fix = 1'b0;
      push_expected(K256, 8, 15);
      send_key(K256, 2'd2);
      wait_v("stall_first_v");
      for (int c = 0; c < 20; c++) begin
         chk("stall_rk0_hold", rk_o, 128'h603deb1015ca71be2b73aef0857d7781);
         chk("stall_idx_hold", 128'({v_o, rk_idx_o}), 128'h10);
         tick();
      end
      yumi_rand = 1'b1;
      drain("aes256_stall");
      yumi_rand = 1'b0;
      yumi_fix = 1'b1;
      chk("stall_rk14", last_rk, 128'hfe4890d1e6188d0b046df344706c631e);

      // Abort while IDLE must win over a presented key
      abort_i = 1'b1; key_i = K128; key_len_i = 2'd0; v_i = 1'b1;
      tick();
      abort_i = 1'b0; v_i = 1'b0;
      chk("abort_over_v_ready", 128'(ready_o), 128'd1);

      // Abort at rk_idx 5 of an AES-128 run, new AES-192 key immediately after
      push_expected(K128, 4, 6);
      send_key(K128, 2'd0);
      n = 0;
      while (!(v_o && rk_idx_o == 4'd5) && n < 100) begin tick(); n++; end
      if (n >= 100) timeout("abort_wait_idx5");
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("abort_v", 128'(v_o), 128'd0);
      chk("abort_ready", 128'(ready_o), 128'd1);
      chk("abort_keys_left", 128'(exp_q.size()), 128'd0);
      push_expected(K192, 6, 13);
      key_i = K192; key_len_i = 2'd1; v_i = 1'b1;
      tick();
      v_i = 1'b0;
      wait_v("abort_new_v");
      chk("abort_new_rk0", rk_o, 128'h8e73b0f7da0e6452c810f32b809079e5);
      drain("abort_aes192");
      chk("abort_aes192_rk12", last_rk, 128'he98ba06f448c773c8ecc720401002202);

      // Illegal key length
      err_cnt = 0;
      key_len_i = 2'd3; v_i = 1'b1;
      tick();
      v_i = 1'b0;
      chk("illegal_err_pulse", 128'(err_o), 128'd1);
      chk("illegal_ready", 128'(ready_o), 128'd1);
      chk("illegal_v", 128'(v_o), 128'd0);
      tick();
      chk("illegal_err_clear", 128'(err_o), 128'd0);
      repeat (5) tick();
      chk("illegal_err_count", 128'(err_cnt), 128'd1);
      chk("illegal_v_after", 128'(v_o), 128'd0);
      chk("illegal_ready_after", 128'(ready_o), 128'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
